// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: mode encoding, FSM states
// and the power-on contents of the constant table.
package imm_pkg;

  localparam logic [1:0] MODE_TBL  = 2'b00;
  localparam logic [1:0] MODE_SEXT = 2'b01;
  localparam logic [1:0] MODE_ZEXT = 2'b10;
  localparam logic [1:0] MODE_PFX  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PFX  = 1'b1
  } imm_state_e;

  // Signed so that entry 5 widens to all ones for any table width.
  localparam int DEFAULT_TBL [8] = '{0, 1, 32, 64, 96, -1, 144, 9};

  function automatic int default_entry(input int idx);
    if (idx < 8) return DEFAULT_TBL[idx[2:0]];
    return 0;
  endfunction

endpackage

// File: rtl/imm_table.sv
// Writable constant table: one write port, one combinational read port,
// synchronous reset back to the default constants.
module imm_table
  import imm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [SEL_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [SEL_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** SEL_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(default_entry(i));
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read is combinational, so a same-cycle write is seen only by later reqs.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/imm_gen.sv
// Decode-stage immediate generator: table lookup, raw sign/zero extension and
// a one-deep prefix that widens the next extended immediate to 2*RAW_W bits.
module imm_gen
  import imm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int RAW_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [RAW_W-1:0]  raw,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] imm_out,
  output logic              imm_valid,
  output logic              pfx_pending
);

  imm_state_e          state_q;
  logic [RAW_W-1:0]    pfx_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   imm_d;
  logic                valid_q;
  logic [DATA_W-1:0]   tbl_rd;
  logic [2*RAW_W-1:0]  wide;

  imm_table #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (sel),
    .rd_data_o (tbl_rd)
  );

  assign wide = {pfx_q, raw};

  // Size casts extend by operand signedness, which also covers 2*RAW_W == DATA_W.
  always_comb begin
    imm_d = imm_q;
    case (mode)
      MODE_TBL:  imm_d = tbl_rd;
      MODE_SEXT: imm_d = (state_q == ST_PFX) ? DATA_W'($signed(wide)) : DATA_W'($signed(raw));
      MODE_ZEXT: imm_d = (state_q == ST_PFX) ? DATA_W'(wide) : DATA_W'(raw);
      default:   imm_d = imm_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pfx_q   <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (req) begin
        if (mode == MODE_PFX) begin
          pfx_q   <= raw;
          state_q <= ST_PFX;
        end else begin
          imm_q   <= imm_d;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign imm_out     = imm_q;
  assign imm_valid   = valid_q;
  assign pfx_pending = (state_q == ST_PFX);

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed literal results.
module tb_imm_gen;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;
  localparam int RAW_W  = 6;

  logic              clk;
  logic              rst;
  logic              req;
  logic [1:0]        mode;
  logic [SEL_W-1:0]  sel;
  logic [RAW_W-1:0]  raw;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] imm_out;
  logic              imm_valid;
  logic              pfx_pending;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  imm_gen #(.DATA_W(DATA_W), .SEL_W(SEL_W), .RAW_W(RAW_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mode        (mode),
    .sel         (sel),
    .raw         (raw),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .imm_out     (imm_out),
    .imm_valid   (imm_valid),
    .pfx_pending (pfx_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [DATA_W-1:0] m_tbl [8];
  logic [DATA_W-1:0] m_imm;
  bit                m_valid;
  bit                m_pend;
  int                m_pfx;

  function automatic logic [DATA_W-1:0] extend(input int v, input int bits, input bit sgn);
    int x;
    x = v;
    if (sgn && v >= (1 << (bits - 1))) x = v - (1 << bits);
    return DATA_W'(x);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_tbl   = '{16'h0000, 16'h0001, 16'h0020, 16'h0040,
                  16'h0060, 16'hFFFF, 16'h0090, 16'h0009};
      m_imm   = '0;
      m_valid = 0;
      m_pend  = 0;
      m_pfx   = 0;
    end else begin
      m_valid = 0;
      if (req) begin
        if (mode == 2'b11) begin
          m_pfx  = int'(raw);
          m_pend = 1;
        end else begin
          if (mode == 2'b00)
            m_imm = m_tbl[sel];
          else if (m_pend)
            m_imm = extend(m_pfx * (1 << RAW_W) + int'(raw), 2 * RAW_W, mode == 2'b01);
          else
            m_imm = extend(int'(raw), RAW_W, mode == 2'b01);
          m_valid = 1;
          m_pend  = 0;
        end
      end
      if (wr_en) m_tbl[wr_addr] = wr_data;
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_imm_out", imm_out, m_imm);
      chk("model_imm_valid", DATA_W'(imm_valid), DATA_W'(m_valid));
      chk("model_pfx_pending", DATA_W'(pfx_pending), DATA_W'(m_pend));
    end
  end

  // driver: apply one cycle of inputs at a negedge, return at the next negedge
  task automatic step(input logic r, input logic [1:0] m, input logic [SEL_W-1:0] s,
                      input logic [RAW_W-1:0] rw, input logic we = 1'b0,
                      input logic [SEL_W-1:0] wa = '0, input logic [DATA_W-1:0] wd = '0);
    req = r; mode = m; sel = s; raw = rw;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    req = 1'b0; wr_en = 1'b0;
  endtask

  task automatic expect_imm(input string name, input logic [DATA_W-1:0] exp);
    chk({name, "_dut"}, imm_out, exp);
    chk({name, "_model"}, m_imm, exp);
    chk({name, "_valid"}, DATA_W'(imm_valid), 16'h0001);
  endtask

  logic [DATA_W-1:0] tbl_exp [8];

  initial begin
    tbl_exp = '{16'h0000, 16'h0001, 16'h0020, 16'h0040,
                16'h0060, 16'hFFFF, 16'h0090, 16'h0009};
    rst = 1'b1; req = 1'b0; mode = 2'b00; sel = '0; raw = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1;
    rst = 1'b0;
    chk("reset_imm_out", imm_out, 16'h0000);
    chk("reset_imm_valid", DATA_W'(imm_valid), 16'h0000);
    chk("reset_pfx_pending", DATA_W'(pfx_pending), 16'h0000);

    // default table, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b00, SEL_W'(i), '0);
      expect_imm($sformatf("tbl_default_%0d", i), tbl_exp[i]);
    end

    // raw extension
    step(1'b1, 2'b01, '0, 6'b111110);
    expect_imm("sext_raw", 16'hFFFE);
    step(1'b1, 2'b10, '0, 6'b111110);
    expect_imm("zext_raw", 16'h003E);

    // prefix with zero extension
    step(1'b1, 2'b11, '0, 6'd3);
    chk("pfx_no_valid", DATA_W'(imm_valid), 16'h0000);
    chk("pfx_pending_set", DATA_W'(pfx_pending), 16'h0001);
    step(1'b1, 2'b10, '0, 6'd5);
    expect_imm("pfx_zext", 16'h00C5);
    chk("pfx_pending_clr", DATA_W'(pfx_pending), 16'h0000);

    // prefix with sign extension
    step(1'b1, 2'b11, '0, 6'b100000);
    step(1'b1, 2'b01, '0, 6'd0);
    expect_imm("pfx_sext", 16'hF800);

    // prefix overwrite: only the latest prefix counts
    step(1'b1, 2'b11, '0, 6'd1);
    step(1'b1, 2'b11, '0, 6'd2);
    chk("pfx_overwrite_pending", DATA_W'(pfx_pending), 16'h0001);
    step(1'b1, 2'b10, '0, 6'd0);
    expect_imm("pfx_overwrite", 16'h0080);

    // write and read the same entry in one cycle
    step(1'b1, 2'b00, 3'd5, '0, 1'b1, 3'd5, 16'h1234);
    expect_imm("wr_rd_same_old", 16'hFFFF);
    step(1'b1, 2'b00, 3'd5, '0);
    expect_imm("wr_rd_same_new", 16'h1234);

    // reset while a prefix is held; a req alongside rst is ignored
    step(1'b1, 2'b11, '0, 6'd7);
    rst = 1'b1;
    step(1'b1, 2'b10, '0, 6'd9);
    rst = 1'b0;
    chk("rst_pfx_pending", DATA_W'(pfx_pending), 16'h0000);
    chk("rst_imm_valid", DATA_W'(imm_valid), 16'h0000);
    chk("rst_imm_out", imm_out, 16'h0000);
    step(1'b1, 2'b10, '0, 6'd1);
    expect_imm("rst_drops_pfx", 16'h0001);
    step(1'b1, 2'b00, 3'd5, '0);
    expect_imm("rst_restores_tbl", 16'hFFFF);

    // table read discards a held prefix
    step(1'b1, 2'b11, '0, 6'd7);
    step(1'b1, 2'b00, 3'd2, '0);
    expect_imm("pfx_then_tbl", 16'h0020);
    chk("pfx_then_tbl_pending", DATA_W'(pfx_pending), 16'h0000);
    step(1'b1, 2'b10, '0, 6'd1);
    expect_imm("pfx_dropped", 16'h0001);

    // idle cycle holds the output
    step(1'b0, 2'b01, '0, 6'd63);
    chk("idle_hold", imm_out, 16'h0001);
    chk("idle_no_valid", DATA_W'(imm_valid), 16'h0000);

    // mixed traffic, checked by the per-cycle model compare
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), SEL_W'($urandom_range(0, 7)),
           RAW_W'($urandom_range(0, 63)), 1'($urandom_range(0, 3) == 0),
           SEL_W'($urandom_range(0, 7)), DATA_W'($urandom_range(0, 65535)));
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
# imm_gen

Parametrised immediate generator for the CPU decode stage. It replaces the fixed 3-bit constant lookup with a run-time writable constant table, sign- and zero-extension of the raw instruction immediate field, and a two-instruction prefix mode that builds wide immediates. The output is registered and feeds the ALU B-operand mux one cycle after the decode request.

## Interface
Parameters:
- DATA_W, 16, width of the generated immediate.
- SEL_W, 3, table select width; table depth DEPTH = 2**SEL_W.
- RAW_W, 6, width of the raw immediate field; 2*RAW_W <= DATA_W is required.

Ports:
- clk  in  1  system clock; the block uses this single clock only.
- rst  in  1  synchronous, active-high reset.
- req  in  1  decode request, valid for one cycle.
- mode  in  2  00 table, 01 sign-extend raw, 10 zero-extend raw, 11 prefix load.
- sel  in  SEL_W  table index (mode 00).
- raw  in  RAW_W  raw immediate field from the instruction.
- wr_en  in  1  table write strobe.
- wr_addr  in  SEL_W  table write index.
- wr_data  in  DATA_W  table write data.
- imm_out  out  DATA_W  generated immediate.
- imm_valid  out  1  imm_out updated this cycle.
- pfx_pending  out  1  a prefix is held and waiting for its consumer.

## Operation
- Reset values: imm_out = 0, imm_valid = 0, pfx_pending = 0, prefix register = 0.
- Reset table contents, entries 0..7: 0, 1, 32, 64, 96, -1 (all ones), 144, 9. Values are truncated to DATA_W. Entries 8 and above reset to 0. If DEPTH < 8, only the first DEPTH entries are used.
- FSM has two states:
  - IDLE: a req with mode 11 stores raw in the prefix register, moves to PFX, and does not assert imm_valid.
  - PFX: pfx_pending = 1.
- mode 00: imm_out = table[sel]. In PFX state, the prefix is discarded and the FSM returns to IDLE.
- mode 01/10 in IDLE: raw is sign- or zero-extended from RAW_W bits to DATA_W.
- mode 01/10 in PFX: the value {prefix, raw} (2*RAW_W bits) is sign- or zero-extended from bit 2*RAW_W-1. The FSM returns to IDLE.
- mode 11 in PFX: the new prefix overwrites the old one and the FSM stays in PFX. There is no multi-level chaining.
- No req: imm_out holds its last value, imm_valid = 0, and the FSM state is unchanged.
- wr_en writes table[wr_addr] <= wr_data at the clock edge, independent of req.

## Timing
- Latency: req at cycle N gives imm_out/imm_valid at cycle N+1, asserted for exactly one cycle per non-prefix req.
- Back-to-back reqs are accepted every cycle. There is no stall and no backpressure.
- Write and read of the same entry in the same cycle: the read returns the old value. The new value is visible from the next req.
- pfx_pending rises in the cycle after a prefix req. It falls in the cycle after the consuming req, when imm_valid rises.
- rst in any state, including PFX: the FSM goes to IDLE, the prefix is dropped, and the table is restored to its reset contents. A req in the same cycle as rst is ignored.

## Structure
- Package imm_pkg holds:
  - the mode encoding constants (MODE_TBL, MODE_SEXT, MODE_ZEXT, MODE_PFX);
  - the FSM state encoding;
  - the 8-entry default-table constant array.
- Sub-module imm_table: a DEPTH x DATA_W register file with synchronous reset-to-defaults, one write port and one combinational read port. imm_gen owns the FSM, the extension logic and the output register.

## Test plan
Defaults for all scenarios: DATA_W=16, RAW_W=6.
- After rst, table reads with sel=0..7 on consecutive cycles -> imm_out = 0x0000, 0x0001, 0x0020, 0x0040, 0x0060, 0xFFFF, 0x0090, 0x0009, each one cycle after its req, with imm_valid pulsed for each.
- raw=6'b111110: mode 01 -> 0xFFFE; mode 10 -> 0x003E.
- Prefix raw=3 then mode 10 raw=5 -> pfx_pending=1 in between, no imm_valid on the prefix, output 0x00C5. Prefix raw=6'b100000 then mode 01 raw=0 -> 0xF800.
- wr_en addr 5 data 0x1234 in the same cycle as a mode 00 read of sel=5 -> 0xFFFF. The next read of sel=5 -> 0x1234.
- Prefix raw=7, then rst, then mode 10 raw=1 -> pfx_pending=0 after rst, output 0x0001. A read of sel=5 -> 0xFFFF (table restored).
- Prefix raw=7 then mode 00 sel=2 -> 0x0020 and pfx_pending clears. The next mode 10 raw=1 -> 0x0001 (prefix dropped).
